fx_arb: RTL and testbench

FX_ARB -- requirements
Module: fx_arb

---
 rtl/fx_arb.sv | 131 +++++++++++++
 tb/tb_fx_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_arb.sv
// rtl/fx_arb.sv - two-requester round-robin arbiter onto the fx register bus
// One transaction outstanding at a time; every output is registered.

module fx_arb #(
    parameter int RD_LAT = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [15:0] m1_rdata,
    output logic [15:0] fx_waddr,
    output logic [15:0] fx_data,
    output logic        fx_wr,
    output logic [15:0] fx_raddr,
    output logic        fx_rd,
    input  logic [15:0] fx_q,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);

    state_t      state;
    logic        prio;
    logic        win;
    logic        cap_wr;
    logic [3:0]  cnt;
    logic        sel;
    logic        sel_wr;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // Priority only matters when both request; otherwise the lone requester wins.
    always_comb begin
        sel       = (m0_req && m1_req) ? prio : m1_req;
        sel_wr    = sel ? m1_wr    : m0_wr;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_wdata = sel ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            win      <= 1'b0;
            cap_wr   <= 1'b0;
            cnt      <= 4'd0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_done  <= 1'b0;
            m1_done  <= 1'b0;
            m0_rdata <= 16'd0;
            m1_rdata <= 16'd0;
            fx_waddr <= 16'd0;
            fx_data  <= 16'd0;
            fx_wr    <= 1'b0;
            fx_raddr <= 16'd0;
            fx_rd    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            fx_wr   <= 1'b0;
            fx_rd   <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        // Grant and bus strobe are launched together so both show in ISSUE.
                        state  <= ISSUE;
                        busy   <= 1'b1;
                        win    <= sel;
                        cap_wr <= sel_wr;
                        prio   <= ~sel;
                        cnt    <= 4'd0;
                        m0_gnt <= ~sel;
                        m1_gnt <= sel;
                        if (sel_wr) begin
                            fx_wr    <= 1'b1;
                            fx_waddr <= sel_addr;
                            fx_data  <= sel_wdata;
                        end else begin
                            fx_rd    <= 1'b1;
                            fx_raddr <= sel_addr;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= 4'd0;
                    if (cap_wr) begin
                        state   <= DONE;
                        m0_done <= ~win;
                        m1_done <= win;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        state   <= DONE;
                        m0_done <= ~win;
                        m1_done <= win;
                        if (win) m1_rdata <= fx_q;
                        else     m0_rdata <= fx_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_arb.sv
// tb/tb_fx_arb.sv - directed and randomized checks of fx_arb against a transaction-level model
// The fx bus responder returns fresh random data exactly RD_LAT cycles after each fx_rd.

module tb_fx_arb;

    localparam int RD_LAT = 2;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [15:0] m0_addr = 16'd0, m0_wdata = 16'd0, m1_addr = 16'd0, m1_wdata = 16'd0;
    logic        m0_gnt, m0_done, m1_gnt, m1_done, fx_wr, fx_rd, busy;
    logic [15:0] m0_rdata, m1_rdata, fx_waddr, fx_data, fx_raddr;
    logic [15:0] fx_q = 16'd0;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_hist = 16'd0;
    logic [15:0] last_resp = 16'd0;

    fx_arb #(.RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .fx_waddr(fx_waddr), .fx_data(fx_data), .fx_wr(fx_wr),
        .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Valid data only on the one cycle the DUT should sample; junk otherwise.
    always @(negedge clk_sys) begin
        rd_hist = {rd_hist[14:0], fx_rd};
        if (rd_hist[RD_LAT]) begin
            last_resp = 16'($urandom);
            fx_q = last_resp;
        end else begin
            fx_q = 16'($urandom);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done, fx_wr, fx_rd, busy} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {m0_gnt, m1_gnt, m0_done, m1_done, fx_wr, fx_rd, busy});
        end
        checks++;
        if ({m0_rdata, m1_rdata, fx_waddr, fx_data, fx_raddr} !== 80'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {m0_rdata, m1_rdata, fx_waddr, fx_data, fx_raddr});
        end
        @(negedge clk_sys);
        rst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk_sys);
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0C05; m0_wdata = 16'hA5A5;
        @(negedge clk_sys);
        checks++;
        if ({m0_gnt, m1_gnt, fx_wr, fx_rd, busy} !== 5'b10101) begin
            errors++;
            $display("FAIL wr_issue got %b exp 10101", {m0_gnt, m1_gnt, fx_wr, fx_rd, busy});
        end
        checks++;
        if ({fx_waddr, fx_data} !== {16'h0C05, 16'hA5A5}) begin
            errors++;
            $display("FAIL wr_bus got %h exp 0c05a5a5", {fx_waddr, fx_data});
        end
        m0_req = 1'b0; m0_addr = 16'hFFFF; m0_wdata = 16'h0000;
        @(negedge clk_sys);
        checks++;
        if ({m0_done, m1_done, fx_wr} !== 3'b100) begin
            errors++;
            $display("FAIL wr_done got %b exp 100", {m0_done, m1_done, fx_wr});
        end
        @(negedge clk_sys);
        checks++;
        if ({busy, m0_done, fx_waddr, fx_data} !== {2'b00, 16'h0C05, 16'hA5A5}) begin
            errors++;
            $display("FAIL wr_after got %h exp 0c05a5a5 busy/done 0", {busy, m0_done, fx_waddr, fx_data});
        end
    endtask

    task automatic test_read();
        @(negedge clk_sys);
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h1003;
        @(negedge clk_sys);
        checks++;
        if ({m1_gnt, m0_gnt, fx_rd, fx_wr, fx_raddr} !== {4'b1010, 16'h1003}) begin
            errors++;
            $display("FAIL rd_issue got %h exp a1003", {m1_gnt, m0_gnt, fx_rd, fx_wr, fx_raddr});
        end
        m1_req = 1'b0; m1_addr = 16'h0000;
        repeat (RD_LAT) begin
            @(negedge clk_sys);
            checks++;
            if ({m1_done, busy} !== 2'b01) begin
                errors++;
                $display("FAIL rd_wait got %b exp 01", {m1_done, busy});
            end
        end
        @(negedge clk_sys);
        checks++;
        if ({m1_done, m0_done, m1_rdata} !== {2'b10, last_resp}) begin
            errors++;
            $display("FAIL rd_done got %h exp %h", {m1_done, m0_done, m1_rdata}, {2'b10, last_resp});
        end
        checks++;
        if (m0_rdata !== 16'd0) begin
            errors++;
            $display("FAIL rd_other got %h exp 0000", m0_rdata);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_back_to_back();
        int gid[$];
        int gcyc[$];
        rst = 1'b1;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0100; m0_wdata = 16'h1111;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0200; m1_wdata = 16'h2222;
        @(negedge clk_sys);
        rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk_sys);
            if (fx_wr && fx_rd) begin
                checks++;
                errors++;
                $display("FAIL b2b_overlap got fx_wr=1 fx_rd=1 exp exclusive");
            end
            if (m0_gnt) begin gid.push_back(0); gcyc.push_back(c); m0_addr = m0_addr + 16'd1; end
            if (m1_gnt) begin gid.push_back(1); gcyc.push_back(c); m1_addr = m1_addr + 16'd1; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++;
        if (gid.size() < 4) begin
            errors++;
            $display("FAIL b2b_count got %0d exp >=4", gid.size());
        end
        for (int i = 0; i < gid.size(); i++) begin
            checks++;
            if (gid[i] != (i % 2) || gcyc[i] != 1 + 3 * i) begin
                errors++;
                $display("FAIL b2b_grant%0d got id %0d cyc %0d exp id %0d cyc %0d", i, gid[i], gcyc[i], i % 2, 1 + 3 * i);
            end
        end
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_reset_mid();
        @(negedge clk_sys);
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0C77;
        @(negedge clk_sys);
        checks++;
        if ({m0_gnt, fx_rd} !== 2'b11) begin
            errors++;
            $display("FAIL mid_issue got %b exp 11", {m0_gnt, fx_rd});
        end
        @(negedge clk_sys);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m0_gnt, m0_done, m1_done, fx_rd, fx_wr, busy, m0_rdata, fx_raddr} !== 38'd0) begin
            errors++;
            $display("FAIL mid_reset got %h exp 0", {m0_gnt, m0_done, m1_done, fx_rd, fx_wr, busy, m0_rdata, fx_raddr});
        end
        @(negedge clk_sys);
        checks++;
        if (m0_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone got %b exp 0", m0_done);
        end
        rst = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({m0_gnt, fx_rd, fx_raddr} !== {2'b11, 16'h0C77}) begin
            errors++;
            $display("FAIL mid_regrant got %h exp 30c77", {m0_gnt, fx_rd, fx_raddr});
        end
        m0_req = 1'b0;
        repeat (RD_LAT + 3) @(negedge clk_sys);
    endtask

    task automatic test_random();
        int          req_cyc[2];
        bit          pend[2];
        int          cd[2];
        logic        twr[2];
        logic [15:0] taddr[2];
        logic [15:0] twd[2];
        logic [15:0] rdv[2];
        int          idle_cyc, done_cyc, gnt_cyc, cur_id, ngnt;
        bit          cur_wr, prio_m, e0, e1, g;
        int          w;
        m0_req = 1'b0; m1_req = 1'b0;
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        idle_cyc = 0; done_cyc = -10; gnt_cyc = -10; cur_id = 0; cur_wr = 1'b1;
        prio_m = 1'b0; ngnt = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; cd[i] = int'($urandom_range(0, 2)); rdv[i] = 16'd0;
            req_cyc[i] = 0; twr[i] = 1'b0; taddr[i] = 16'd0; twd[i] = 16'd0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk_sys);
                e0 = pend[0] && req_cyc[0] <= cyc - 1;
                e1 = pend[1] && req_cyc[1] <= cyc - 1;
                g  = (idle_cyc <= cyc - 1) && (e0 || e1);
                w  = (e0 && e1) ? int'(prio_m) : int'(e1);
                checks++;
                if ({m0_gnt, m1_gnt} !== {g && w == 0, g && w == 1}) begin
                    errors++;
                    $display("FAIL rnd_gnt cyc %0d got %b exp %b", cyc, {m0_gnt, m1_gnt}, {g && w == 0, g && w == 1});
                end
                checks++;
                if ({fx_wr, fx_rd} !== {g && twr[w], g && !twr[w]}) begin
                    errors++;
                    $display("FAIL rnd_strobe cyc %0d got %b exp %b", cyc, {fx_wr, fx_rd}, {g && twr[w], g && !twr[w]});
                end
                if (g) begin
                    checks++;
                    if (twr[w] ? ({fx_waddr, fx_data} !== {taddr[w], twd[w]}) : (fx_raddr !== taddr[w])) begin
                        errors++;
                        $display("FAIL rnd_bus cyc %0d got %h/%h/%h exp %h/%h", cyc, fx_waddr, fx_data, fx_raddr, taddr[w], twd[w]);
                    end
                    gnt_cyc  = cyc;
                    done_cyc = twr[w] ? cyc + 1 : cyc + 1 + RD_LAT;
                    idle_cyc = done_cyc + 1;
                    prio_m   = (w == 0);
                    cur_id   = w;
                    cur_wr   = twr[w];
                    pend[w]  = 1'b0;
                    cd[w]    = int'($urandom_range(0, 4));
                    ngnt++;
                end
                checks++;
                if (busy !== (cyc >= gnt_cyc && cyc <= done_cyc)) begin
                    errors++;
                    $display("FAIL rnd_busy cyc %0d got %b", cyc, busy);
                end
                checks++;
                if ({m0_done, m1_done} !== {cyc == done_cyc && cur_id == 0, cyc == done_cyc && cur_id == 1}) begin
                    errors++;
                    $display("FAIL rnd_done cyc %0d got %b exp id %0d at %0d", cyc, {m0_done, m1_done}, cur_id, done_cyc);
                end
                if (cyc == done_cyc && !cur_wr) rdv[cur_id] = last_resp;
                checks++;
                if ({m0_rdata, m1_rdata} !== {rdv[0], rdv[1]}) begin
                    errors++;
                    $display("FAIL rnd_rdata cyc %0d got %h %h exp %h %h", cyc, m0_rdata, m1_rdata, rdv[0], rdv[1]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if (cd[i] > 0) cd[i]--;
                    else begin
                        pend[i] = 1'b1; req_cyc[i] = cyc; twr[i] = 1'($urandom);
                        taddr[i] = 16'($urandom); twd[i] = 16'($urandom);
                    end
                end
            end
            m0_req = pend[0]; m0_wr = pend[0] ? twr[0] : 1'($urandom);
            m0_addr = pend[0] ? taddr[0] : 16'($urandom); m0_wdata = pend[0] ? twd[0] : 16'($urandom);
            m1_req = pend[1]; m1_wr = pend[1] ? twr[1] : 1'($urandom);
            m1_addr = pend[1] ? taddr[1] : 16'($urandom); m1_wdata = pend[1] ? twd[1] : 16'($urandom);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++;
        if (ngnt < 50) begin
            errors++;
            $display("FAIL rnd_progress got %0d grants exp >=50", ngnt);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
